// File: rtl/tcp_tx_buf.sv
// -----------------------------------------------------------------------------
// tcp_tx_buf
//
// Transmit-side byte buffer that feeds the TCP segment builder. User bytes are
// written into an internal FIFO. A segment is cut when MSS bytes are buffered,
// when the user forces a flush with in_snd, or when the buffer has been idle
// for WAIT_TICKS cycles. The segment length is announced on the descriptor
// port first, and then exactly that many bytes are streamed out.
//
// Optional feature macro: TCP_TX_BUF_STATS_EN
//   When defined, two statistics outputs are added: stat_seg and stat_drop.
//   When undefined, those ports and counters do not exist, and bytes written
//   into a full FIFO are still dropped silently.
//
// Parameters
//   DEPTH       FIFO size in bytes. Must be a power of 2 and >= 2*MSS.
//   MSS         Maximum segment payload in bytes (1..65535).
//   WAIT_TICKS  Idle cycles after the last accepted byte before a partial
//               segment is flushed (>= 1).
//
// Ports
//   clk, rst_n            Clock (rising edge). Reset is asynchronous and
//                         active-low.
//   in_dat/in_val/in_snd  User byte, byte valid, and force-flush request.
//   in_cts                Registered clear-to-send. It is high while at least
//                         two FIFO slots are free.
//   seg_val/seg_len       Segment descriptor and its payload length.
//   seg_rdy               Builder accepts the descriptor.
//   out_dat/out_val       Payload byte and byte valid.
//   out_last              Marks the final byte of the segment.
//   out_rdy               Builder accepts the payload byte.
//   stat_seg  (optional)  Saturating count of accepted descriptors.
//   stat_drop (optional)  Saturating count of dropped bytes.
// -----------------------------------------------------------------------------
module tcp_tx_buf #(
  parameter int DEPTH      = 2048,
  parameter int MSS        = 1460,
  parameter int WAIT_TICKS = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_dat,
  input  logic        in_val,
  input  logic        in_snd,
  output logic        in_cts,
  output logic        seg_val,
  output logic [15:0] seg_len,
  input  logic        seg_rdy,
  output logic [7:0]  out_dat,
  output logic        out_val,
  output logic        out_last,
  input  logic        out_rdy
`ifdef TCP_TX_BUF_STATS_EN
  ,
  output logic [31:0] stat_seg,
  output logic [15:0] stat_drop
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam int IW = $clog2(WAIT_TICKS + 1);

  localparam logic [FW-1:0] FULL_LVL = FW'(DEPTH);
  localparam logic [FW-1:0] CTS_LVL  = FW'(DEPTH - 2);
  localparam logic [FW-1:0] MSS_LVL  = FW'(MSS);
  localparam logic [IW-1:0] IDLE_MAX = IW'(WAIT_TICKS);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ANNOUNCE = 2'd1,
    STREAM   = 2'd2
  } state_t;

  // Saturating increment of the idle timer. It stops at WAIT_TICKS so that
  // the flush condition stays true until the buffer is drained.
  function automatic logic [IW-1:0] sat_idle(input logic [IW-1:0] v);
    if (v >= IDLE_MAX) return v;
    return v + IW'(1);
  endfunction

`ifdef TCP_TX_BUF_STATS_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    if (v == '1) return v;
    return v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == '1) return v;
    return v + 16'd1;
  endfunction
`endif

  // Storage is data only, so it is not reset. The pointers and fill count
  // define which entries are valid.
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [FW-1:0] fill;
  logic [FW-1:0] fill_next;
  logic [IW-1:0] idle_cnt;
  logic          snd_pend;
  logic [15:0]   rem;

  state_t state;
  state_t state_next;

  logic wr_en;
  logic rd_en;
  logic trigger;
  logic seg_load;
  logic seg_acc;

  assign wr_en     = in_val && (fill != FULL_LVL);
  assign rd_en     = (state == STREAM) && out_rdy;
  assign fill_next = fill + {{(FW-1){1'b0}}, wr_en} - {{(FW-1){1'b0}}, rd_en};

  // All three cut conditions produce the same length rule. The trigger only
  // looks at the registered fill, so bytes written in the trigger cycle are
  // not counted toward this segment.
  assign trigger = (fill >= MSS_LVL) ||
                   ((fill != '0) && (snd_pend || (idle_cnt == IDLE_MAX)));

  // The head is read combinationally. The output is forced to 0 outside
  // STREAM, so it reads 0 while the block is held in reset.
  assign out_dat = (state == STREAM) ? mem[rd_ptr] : 8'h00;

  // ---------------------------------------------------------------------------
  // FIFO write side and occupancy
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= in_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
      in_cts <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      fill   <= fill_next;
      // One slot of headroom lets the user see in_cts fall one tick late
      // without losing a byte.
      in_cts <= (fill_next <= CTS_LVL);
    end
  end

  // ---------------------------------------------------------------------------
  // Flush bookkeeping: idle timer and pending-send flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
      snd_pend <= 1'b0;
    end else begin
      if (wr_en || (fill == '0)) idle_cnt <= '0;
      else                       idle_cnt <= sat_idle(idle_cnt);

      // The flag clears only when the accepted descriptor covers everything
      // still buffered. A new in_snd in the same cycle wins, so that bytes
      // arriving alongside it are still flushed.
      if (seg_acc && (fill == FW'(seg_len))) snd_pend <= 1'b0;
      if (in_snd && ((fill != '0) || in_val)) snd_pend <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Segment FSM: state register and length/remaining counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      seg_len <= 16'h0000;
      rem     <= 16'h0000;
    end else begin
      state <= state_next;
      if (seg_load) seg_len <= (fill >= MSS_LVL) ? 16'(MSS) : 16'(fill);
      if (seg_acc)       rem <= seg_len;
      else if (rd_en)    rem <= rem - 16'd1;
    end
  end

  always_comb begin
    state_next = state;
    seg_load   = 1'b0;
    seg_acc    = 1'b0;
    seg_val    = 1'b0;
    out_val    = 1'b0;
    out_last   = 1'b0;
    case (state)
      IDLE: begin
        if (trigger) begin
          state_next = ANNOUNCE;
          seg_load   = 1'b1;
        end
      end
      ANNOUNCE: begin
        seg_val = 1'b1;
        if (seg_rdy) begin
          state_next = STREAM;
          seg_acc    = 1'b1;
        end
      end
      STREAM: begin
        out_val  = 1'b1;
        out_last = (rem == 16'd1);
        if (out_rdy && (rem == 16'd1)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef TCP_TX_BUF_STATS_EN
  // ---------------------------------------------------------------------------
  // Statistics counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_seg  <= 32'd0;
      stat_drop <= 16'd0;
    end else begin
      if (seg_acc)           stat_seg  <= sat_inc32(stat_seg);
      if (in_val && !wr_en)  stat_drop <= sat_inc16(stat_drop);
    end
  end
`endif

endmodule

// File: tb/tb_tcp_tx_buf.sv
// -----------------------------------------------------------------------------
// tb_tcp_tx_buf
//
// Directed, self-checking bench for tcp_tx_buf with DEPTH=16, MSS=8 and
// WAIT_TICKS=5. Inputs change 1 time unit after the rising edge. Outputs are
// sampled at that same point, after the edge has settled.
// -----------------------------------------------------------------------------
module tb_tcp_tx_buf;
  localparam int DEPTH      = 16;
  localparam int MSS        = 8;
  localparam int WAIT_TICKS = 5;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic [7:0]  in_dat = 8'h00;
  logic        in_val = 1'b0;
  logic        in_snd = 1'b0;
  logic        seg_rdy = 1'b0;
  logic        out_rdy = 1'b0;
  logic        in_cts;
  logic        seg_val;
  logic [15:0] seg_len;
  logic [7:0]  out_dat;
  logic        out_val;
  logic        out_last;
`ifdef TCP_TX_BUF_STATS_EN
  logic [31:0] stat_seg;
  logic [15:0] stat_drop;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tcp_tx_buf #(.DEPTH(DEPTH), .MSS(MSS), .WAIT_TICKS(WAIT_TICKS)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_dat(in_dat), .in_val(in_val), .in_snd(in_snd), .in_cts(in_cts),
    .seg_val(seg_val), .seg_len(seg_len), .seg_rdy(seg_rdy),
    .out_dat(out_dat), .out_val(out_val), .out_last(out_last), .out_rdy(out_rdy)
`ifdef TCP_TX_BUF_STATS_EN
    , .stat_seg(stat_seg), .stat_drop(stat_drop)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    checks++; if (in_cts !== 1'b0) begin errors++; $display("FAIL reset_in_cts got %0b exp 0", in_cts); end
    checks++; if (seg_val !== 1'b0) begin errors++; $display("FAIL reset_seg_val got %0b exp 0", seg_val); end
    checks++; if (seg_len !== 16'h0) begin errors++; $display("FAIL reset_seg_len got %0h exp 0", seg_len); end
    checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL reset_out_val got %0b exp 0", out_val); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %0b exp 0", out_last); end
    checks++; if (out_dat !== 8'h00) begin errors++; $display("FAIL reset_out_dat got %0h exp 0", out_dat); end
    rst_n = 1'b1;
    step();
    checks++; if (in_cts !== 1'b1) begin errors++; $display("FAIL reset_cts_rise got %0b exp 1", in_cts); end
  endtask

  task automatic test_mss_cut();
    seg_rdy = 1'b1; out_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin in_val = 1'b1; in_dat = 8'(i); step(); end
    in_val = 1'b0;
    checks++; if (seg_val !== 1'b0) begin errors++; $display("FAIL mss_early got %0b exp 0", seg_val); end
    step();
    checks++; if (seg_val !== 1'b1 || seg_len !== 16'd8) begin errors++; $display("FAIL mss_desc got val=%0b len=%0d exp val=1 len=8", seg_val, seg_len); end
    step();
    for (int k = 0; k < 8; k++) begin
      checks++; if (out_val !== 1'b1 || out_dat !== 8'(k)) begin errors++; $display("FAIL mss_byte%0d got val=%0b dat=%0h exp val=1 dat=%0h", k, out_val, out_dat, k); end
      checks++; if (out_last !== (k == 7)) begin errors++; $display("FAIL mss_last%0d got %0b exp %0b", k, out_last, (k == 7)); end
      step();
    end
    checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL mss_end got %0b exp 0", out_val); end
  endtask

  task automatic test_idle_flush();
    seg_rdy = 1'b1; out_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin in_val = 1'b1; in_dat = 8'h10 + 8'(i); step(); end
    in_val = 1'b0;
    repeat (5) step();
    checks++; if (seg_val !== 1'b0) begin errors++; $display("FAIL idle_early got %0b exp 0", seg_val); end
    step();
    checks++; if (seg_val !== 1'b1 || seg_len !== 16'd3) begin errors++; $display("FAIL idle_desc got val=%0b len=%0d exp val=1 len=3", seg_val, seg_len); end
    step();
    for (int k = 0; k < 3; k++) begin
      checks++; if (out_val !== 1'b1 || out_dat !== 8'h10 + 8'(k)) begin errors++; $display("FAIL idle_byte%0d got val=%0b dat=%0h exp val=1 dat=%0h", k, out_val, out_dat, 8'h10 + 8'(k)); end
      checks++; if (out_last !== (k == 2)) begin errors++; $display("FAIL idle_last%0d got %0b exp %0b", k, out_last, (k == 2)); end
      step();
    end
  endtask

  task automatic test_snd();
    bit seen;
    seg_rdy = 1'b1; out_rdy = 1'b1;
    in_val = 1'b1; in_dat = 8'h20; step();
    in_dat = 8'h21; in_snd = 1'b1; step();
    in_val = 1'b0; in_snd = 1'b0;
    checks++; if (seg_val !== 1'b0) begin errors++; $display("FAIL snd_early got %0b exp 0", seg_val); end
    step();
    checks++; if (seg_val !== 1'b1 || seg_len !== 16'd2) begin errors++; $display("FAIL snd_desc got val=%0b len=%0d exp val=1 len=2", seg_val, seg_len); end
    step();
    for (int k = 0; k < 2; k++) begin
      checks++; if (out_val !== 1'b1 || out_dat !== 8'h20 + 8'(k) || out_last !== (k == 1)) begin errors++; $display("FAIL snd_byte%0d got val=%0b dat=%0h last=%0b exp val=1 dat=%0h last=%0b", k, out_val, out_dat, out_last, 8'h20 + 8'(k), (k == 1)); end
      step();
    end
    in_snd = 1'b1; step(); in_snd = 1'b0;
    checks++; if (dut.snd_pend !== 1'b0) begin errors++; $display("FAIL snd_empty_pend got %0b exp 0", dut.snd_pend); end
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin if (seg_val) seen = 1'b1; step(); end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL snd_empty_desc got %0b exp 0", seen); end
  endtask

  task automatic test_backpressure();
    int nb, nl, nd;
    seg_rdy = 1'b0; out_rdy = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      in_val = 1'b1; in_dat = 8'h30 + 8'(n - 1); step();
      if (n == 13) begin checks++; if (in_cts !== 1'b1) begin errors++; $display("FAIL bp_cts13 got %0b exp 1", in_cts); end end
      if (n == 15) begin checks++; if (in_cts !== 1'b0) begin errors++; $display("FAIL bp_cts15 got %0b exp 0", in_cts); end end
    end
    in_val = 1'b0;
    checks++; if (seg_val !== 1'b1 || seg_len !== 16'd8) begin errors++; $display("FAIL bp_desc got val=%0b len=%0d exp val=1 len=8", seg_val, seg_len); end
`ifdef TCP_TX_BUF_STATS_EN
    checks++; if (stat_drop !== 16'd4) begin errors++; $display("FAIL bp_drop got %0d exp 4", stat_drop); end
`endif
    seg_rdy = 1'b1;
    nb = 0; nl = 0; nd = 0;
    for (int c = 0; c < 60; c++) begin
      if (seg_val) begin
        nd++;
        checks++; if (seg_len !== 16'd8) begin errors++; $display("FAIL bp_seglen got %0d exp 8", seg_len); end
      end
      if (out_val) begin
        checks++; if (out_dat !== 8'h30 + 8'(nb)) begin errors++; $display("FAIL bp_byte%0d got %0h exp %0h", nb, out_dat, 8'h30 + 8'(nb)); end
        if (out_last) nl++;
        nb++;
      end
      step();
    end
    checks++; if (nb != 16) begin errors++; $display("FAIL bp_count got %0d exp 16", nb); end
    checks++; if (nl != 2 || nd != 2) begin errors++; $display("FAIL bp_segs got last=%0d desc=%0d exp 2 2", nl, nd); end
    checks++; if (in_cts !== 1'b1) begin errors++; $display("FAIL bp_cts_end got %0b exp 1", in_cts); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] lens[$];
    int nb, last_c, second_c;
    seg_rdy = 1'b0; out_rdy = 1'b1;
    for (int i = 0; i < 13; i++) begin in_val = 1'b1; in_dat = 8'h40 + 8'(i); step(); end
    in_val = 1'b0; in_snd = 1'b1; step(); in_snd = 1'b0;
    checks++; if (seg_val !== 1'b1 || seg_len !== 16'd8) begin errors++; $display("FAIL b2b_desc1 got val=%0b len=%0d exp val=1 len=8", seg_val, seg_len); end
    checks++; if (dut.snd_pend !== 1'b1) begin errors++; $display("FAIL b2b_pend_set got %0b exp 1", dut.snd_pend); end
    seg_rdy = 1'b1;
    nb = 0; last_c = -1; second_c = -1;
    for (int c = 0; c < 60; c++) begin
      if (seg_val) begin lens.push_back(seg_len); if (lens.size() == 2) second_c = c; end
      if (out_val) begin
        checks++; if (out_dat !== 8'h40 + 8'(nb) || out_last !== (nb == 7 || nb == 12)) begin errors++; $display("FAIL b2b_byte%0d got dat=%0h last=%0b exp dat=%0h last=%0b", nb, out_dat, out_last, 8'h40 + 8'(nb), (nb == 7 || nb == 12)); end
        if (out_last && last_c < 0) last_c = c;
        nb++;
      end
      step();
    end
    checks++; if (lens.size() != 2) begin errors++; $display("FAIL b2b_ndesc got %0d exp 2", lens.size()); end
    else begin
      checks++; if (lens[0] !== 16'd8 || lens[1] !== 16'd5) begin errors++; $display("FAIL b2b_lens got %0d,%0d exp 8,5", lens[0], lens[1]); end
    end
    checks++; if (nb != 13) begin errors++; $display("FAIL b2b_count got %0d exp 13", nb); end
    checks++; if (second_c - last_c != 2) begin errors++; $display("FAIL b2b_gap got %0d exp 2", second_c - last_c); end
    checks++; if (dut.snd_pend !== 1'b0) begin errors++; $display("FAIL b2b_pend_clr got %0b exp 0", dut.snd_pend); end
`ifdef TCP_TX_BUF_STATS_EN
    checks++; if (stat_seg !== 32'd7) begin errors++; $display("FAIL b2b_stat_seg got %0d exp 7", stat_seg); end
`endif
  endtask

  task automatic test_reset_mid();
    bit found, seen;
    seg_rdy = 1'b1; out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin in_val = 1'b1; in_dat = 8'h50 + 8'(i); step(); end
    in_val = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin if (out_val) found = 1'b1; else step(); end
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL rstmid_stream got %0b exp 1", found); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_val !== 1'b0 || seg_val !== 1'b0 || in_cts !== 1'b0) begin errors++; $display("FAIL rstmid_async got out=%0b seg=%0b cts=%0b exp 0 0 0", out_val, seg_val, in_cts); end
    step();
    rst_n = 1'b1;
    step();
    checks++; if (in_cts !== 1'b1) begin errors++; $display("FAIL rstmid_cts got %0b exp 1", in_cts); end
    out_rdy = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 15; c++) begin if (out_val || seg_val) seen = 1'b1; step(); end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rstmid_residual got %0b exp 0", seen); end
  endtask

  initial begin
    test_reset();
    test_mss_cut();
    test_idle_flush();
    test_snd();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "timeout");
  end

endmodule
